// File: rtl/operand_serial_tx.sv
// operand_serial_tx
// Serial transmitter for 8-bit operand words {a[3:0], b[3:0]}. One word is
// taken per valid/ready handshake and sent as an asynchronous frame:
// start bit (0), 8 data bits LSB first, optional even-parity bit, stop bit (1).
//
// Parameters:
//   CLKS_PER_BIT  clock cycles each serial bit is held on tx (1..255)
//   PARITY_EN     1 inserts an even-parity bit after data bit 7
//
// Ports:
//   clk      system clock, rising edge active
//   rst_n    asynchronous active-low reset; aborts any frame in progress
//   data_in  operand word {a,b}: data_in[7:4] = a, data_in[3:0] = b
//   valid    source has a word on data_in
//   ready    word can be accepted this cycle (state is IDLE)
//   tx       serial line, idles high (registered)
//   busy     frame in progress (inverse of ready)
//   done     one-cycle pulse during the last cycle of the stop bit (registered)
module operand_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  // Cycle before the last stop cycle; done is registered, so it is set here.
  // With CLKS_PER_BIT=1 every cycle is a bit boundary and this is never used.
  localparam logic [7:0] BAUD_PRE  = 8'(CLKS_PER_BIT - 2);
  localparam logic       ONE_CLK   = (CLKS_PER_BIT == 1);

  state_t     state;
  logic [7:0] shift;
  logic [2:0] idx;
  logic [7:0] baud;
  logic       bit_end;
  logic [2:0] idx_nx;

  assign bit_end = (baud == BAUD_LAST);
  assign idx_nx  = idx + 3'd1;
  assign ready   = (state == IDLE);
  assign busy    = ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shift <= 8'd0;
      idx   <= 3'd0;
      baud  <= 8'd0;
      tx    <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) begin
        baud <= bit_end ? 8'd0 : baud + 8'd1;
      end
      unique case (state)
        IDLE: begin
          if (valid) begin
            state <= START;
            shift <= data_in;
            idx   <= 3'd0;
            baud  <= 8'd0;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            // idx wraps 7 -> 0 on the way out, leaving it cleared for the next frame
            idx <= idx_nx;
            if (idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= ^shift;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
                done  <= ONE_CLK;
              end
            end else begin
              tx <= shift[idx_nx];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
            done  <= ONE_CLK;
          end
        end
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            tx    <= 1'b1;
          end else if (baud == BAUD_PRE) begin
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_serial_tx.sv
// Bench for operand_serial_tx. Three instances cover the configurations:
//   u0: CLKS_PER_BIT=4, PARITY_EN=0
//   u1: CLKS_PER_BIT=4, PARITY_EN=1
//   u2: CLKS_PER_BIT=1, PARITY_EN=0
// Drivers push {word, acceptance cycle} into a per-instance queue on each
// handshake; a monitor per instance decodes the serial line and compares it
// with the frame built from the queued word.
module tb_operand_serial_tx;

  typedef struct {
    logic [7:0] w;
    int         acc;
    bit         b2b;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] vld;
  logic [7:0] din [3];
  wire  [2:0] tx_w;
  wire  [2:0] ready_w;
  wire  [2:0] busy_w;
  wire  [2:0] done_w;

  int   cyc;
  int   total;
  int   bad;
  exp_t q [3][$];

  operand_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
    .clk(clk), .rst_n(rst_n), .data_in(din[0]), .valid(vld[0]),
    .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  operand_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(din[1]), .valid(vld[1]),
    .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  operand_serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(0)) u2 (
    .clk(clk), .rst_n(rst_n), .data_in(din[2]), .valid(vld[2]),
    .ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected line level for frame bit b (0 = start, 1..8 = data LSB first).
  function automatic logic ebit(input logic [7:0] w, input int b, input int p);
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (p != 0 && b == 9) return ^w;
    return 1'b1;
  endfunction

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send(input int k, input logic [7:0] w, input bit b2b);
    exp_t e;
    int   t;
    t = 0;
    din[k] = w;
    vld[k] = 1'b1;
    while (ready_w[k] !== 1'b1) begin
      @(negedge clk);
      t++;
      if (t > 3000) begin
        chk("send_timeout", 0, 1);
        vld[k] = 1'b0;
        return;
      end
    end
    e.w   = w;
    e.acc = cyc + 1;
    e.b2b = b2b;
    q[k].push_back(e);
    @(negedge clk);
    vld[k] = 1'b0;
    din[k] = 8'($urandom);
  endtask

  task automatic monitor(input int k, input int c, input int p);
    exp_t e;
    int   n;
    int   last_end;
    int   bit_err;
    int   done_err;
    int   busy_err;
    bit   aborted;
    last_end = -100;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) continue;
      if (tx_w[k] !== 1'b0) continue;
      if (q[k].size() == 0) begin
        chk($sformatf("unexpected_frame_u%0d", k), 1, 0);
        continue;
      end
      e = q[k].pop_front();
      chk($sformatf("start_cycle_u%0d", k), cyc, e.acc);
      if (e.b2b) chk($sformatf("b2b_gap_u%0d", k), cyc - last_end, 2);
      n        = (10 + p) * c;
      bit_err  = 0;
      done_err = 0;
      busy_err = 0;
      aborted  = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        if (rst_n !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if (tx_w[k] !== ebit(e.w, i / c, p)) bit_err++;
        if (done_w[k] !== (i == n - 1)) done_err++;
        if (busy_w[k] !== 1'b1 || ready_w[k] !== 1'b0) busy_err++;
      end
      if (aborted) continue;
      last_end = cyc;
      chk($sformatf("frame_bits_u%0d_w%02h", k, e.w), bit_err, 0);
      chk($sformatf("done_pulse_u%0d", k), done_err, 0);
      chk($sformatf("busy_in_frame_u%0d", k), busy_err, 0);
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk($sformatf("post_frame_idle_u%0d", k),
            {ready_w[k], busy_w[k], tx_w[k], done_w[k]}, 4'b1010);
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q[0].size() + q[1].size() + q[2].size() != 0 || ready_w !== 3'b111) begin
      @(negedge clk);
      t++;
      if (t > 5000) begin
        chk("drain_timeout", 0, 1);
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_drive(input int k, input int n);
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 3);
      if (i > 0 && gap != 0) repeat (gap * 7) @(negedge clk);
      send(k, 8'($urandom), (i > 0 && gap == 0));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    vld   = 3'b000;
    for (int i = 0; i < 3; i++) din[i] = 8'h00;
    fork
      monitor(0, 4, 0);
      monitor(1, 4, 1);
      monitor(2, 1, 0);
    join_none

    // reset held 3 cycles, then idle with valid low
    repeat (3) @(negedge clk);
    chk("tx_in_reset", tx_w, 3'b111);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_tx", tx_w, 3'b111);
    chk("reset_ready", ready_w, 3'b111);
    chk("reset_busy", busy_w, 3'b000);
    chk("reset_done", done_w, 3'b000);
    repeat (20) @(negedge clk);
    chk("idle_tx_20", tx_w, 3'b111);

    // single frame, parity words, CLKS_PER_BIT=1 back-to-back
    fork
      send(0, 8'b0011_0011, 1'b0);
      begin
        send(1, 8'b1111_0011, 1'b0);
        send(1, 8'b0001_0001, 1'b1);
        send(1, 8'b0000_0011, 1'b1);
        send(1, 8'b0000_0001, 1'b1);
      end
      begin
        send(2, 8'h00, 1'b0);
        send(2, 8'hFF, 1'b1);
      end
    join
    drain();

    // valid held through the first frame while data_in changes to 00
    send(0, 8'hFF, 1'b0);
    send(0, 8'h00, 1'b1);
    drain();

    // reset during data bit 3 of 8'h11 (frame bit 4, samples 16..19)
    send(0, 8'h11, 1'b0);
    repeat (17) @(negedge clk);
    #1 chk("tx_before_abort", tx_w[0], 0);
    rst_n = 1'b0;
    #1 chk("tx_async_reset", tx_w[0], 1);
    chk("ready_async_reset", ready_w[0], 1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", ready_w[0], 1);
    send(0, 8'h03, 1'b0);
    drain();

    // randomized traffic on all three instances
    fork
      rand_drive(0, 12);
      rand_drive(1, 12);
      rand_drive(2, 30);
    join
    drain();
    chk("queues_empty", q[0].size() + q[1].size() + q[2].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_serial_tx.md
Name: operand_serial_tx

Overview:
- Serial transmitter for 8-bit operand words {a[3:0], b[3:0]} that feed the 4-bit two-operand exercise units.
- Accepts one word per valid/ready handshake and shifts it out on a single line as an asynchronous frame: start bit, 8 data bits LSB first, optional even parity bit, stop bit.
- Sits between the operand source (bench or front-end logic) and a serial link; the matching receiver reassembles {a,b} at the far end.

Parameters:
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx; legal range 1..255.
- PARITY_EN, 0, 1 inserts an even-parity bit between data bit 7 and the stop bit; 0 omits it.

Ports:
- clk  input  1  system clock, rising edge active.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  8  operand word {a,b}; data_in[7:4] = a, data_in[3:0] = b.
- valid  input  1  source asserts when data_in holds a word to send.
- ready  output  1  high when a word can be accepted.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (async, rst_n low): state IDLE, tx=1, ready=1, busy=0, done=0, shift register, bit counter and baud counter cleared.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 without waiting for a clock edge.
  - After rst_n deasserts, the first handshake can occur on the next rising edge.
- Handshake: a word is accepted on the rising edge where valid=1 and ready=1.
  - data_in is latched into an internal shift register on that edge.
  - Changes on data_in after acceptance do not affect the frame.
- ready is combinationally equal to (state==IDLE). valid while busy is ignored; no queueing.
- FSM states and transitions:
  - IDLE: tx=1. On acceptance go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[index] for CLKS_PER_BIT cycles per bit, LSB first (data_in[0] first, data_in[7] last). After index 7, go to PARITY if PARITY_EN=1, otherwise go to STOP.
  - PARITY: tx = XOR of the 8 latched bits (even parity: total ones including the parity bit is even); held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. done=1 on the final cycle, then go to IDLE.
- Latency: tx falls on the first rising edge after acceptance (registered output).
- Frame length: (10 + PARITY_EN) × CLKS_PER_BIT cycles from that edge until ready returns high.
- busy = !ready.
- Back-to-back frames: if valid=1 in the first IDLE cycle after done, a new frame starts. Minimum gap between frames is one IDLE cycle with tx=1.
- Baud counter: 8 bits, counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. With CLKS_PER_BIT=1, each bit lasts exactly one cycle.
- Bit index: 3 bits; the wrap from 7 to 0 is the DATA-exit condition.
- All outputs are registered except ready and busy, which are decoded directly from the state register.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4, PARITY_EN=0: hold rst_n=0 for 3 cycles then release → tx=1, ready=1, busy=0, done=0; tx stays 1 for 20 cycles with valid=0.
- Single frame, data_in=8'b00110011, valid for 1 cycle → tx sequence per 4-cycle bit: 0,1,1,0,0,1,1,0,0,1. done pulses once, at cycle 40 after acceptance. ready=1 at cycle 41.
- Parity, PARITY_EN=1, data_in=8'b11110011 (6 ones) → parity bit 0. data_in=8'b00010001 (2 ones) → parity 0. data_in=8'b00000011 → parity 0. data_in=8'b00000001 → parity 1. Frame length is 44 cycles.
- Busy rejection: accept 8'hFF, then change data_in to 8'h00 and hold valid=1 throughout → first frame carries eight 1 data bits. Second frame (8'h00) starts exactly one IDLE cycle after done.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 8'h11 → tx=1 immediately, asynchronously. After release, ready=1, and a new word 8'h03 transmits a complete, correct frame.
- CLKS_PER_BIT=1: send 8'h00 then 8'hFF back-to-back → frames of 10 cycles each, separated by one idle-high cycle. done pulses twice.
